// File: rtl/dot_product_ctrl_if.sv
// rtl/dot_product_ctrl_if.sv - single-outstanding memory request/response port of the dot-product sequencer
// The sequencer drives the master side; the shared memory port sits on the slave side.
interface dot_product_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [31:0]       mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );
endinterface

// File: rtl/dot_product_ctrl.sv
// rtl/dot_product_ctrl.sv - dot-product sequencer: fetches A[i]/B[i], multiply-accumulates, writes the 64-bit sum
// Define ACC_SAT_EN for signed saturating accumulation; otherwise the accumulator wraps modulo 2^64.
module dot_product_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 64,
  parameter int MAX_LEN = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [31:0]         ctrl_reg,
  input  logic [31:0]         vec_a_addr,
  input  logic [31:0]         vec_b_addr,
  input  logic [31:0]         vec_len,
  input  logic [31:0]         out_addr,
  dot_product_ctrl_if.master  mem,
  output logic                set_busy,
  output logic                set_done,
  output logic                set_error,
  output logic                busy,
  output logic [ACC_W-1:0]    result
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RD_A    = 4'd1;
  localparam logic [3:0] S_WAIT_A  = 4'd2;
  localparam logic [3:0] S_RD_B    = 4'd3;
  localparam logic [3:0] S_WAIT_B  = 4'd4;
  localparam logic [3:0] S_MAC     = 4'd5;
  localparam logic [3:0] S_WR_LO   = 4'd6;
  localparam logic [3:0] S_WAIT_WL = 4'd7;
  localparam logic [3:0] S_WR_HI   = 4'd8;
  localparam logic [3:0] S_WAIT_WH = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;
  localparam logic [3:0] S_ERR     = 4'd11;

  logic [3:0]        state_q, state_d;
  logic              start_ff_q;
  logic              busy_pulse_q, busy_pulse_d;
  logic [31:0]       a_ptr_q, a_ptr_d;
  logic [31:0]       b_ptr_q, b_ptr_d;
  logic [31:0]       out_q, out_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  result_q, result_d;

  logic              start;
  logic              cfg_bad;
  logic [IDX_W-1:0]  idx_nxt;
  logic [ACC_W-1:0]  a_ext, b_ext, prod, sum, mac_val;
  logic              unused_ctrl;

  assign unused_ctrl = ^ctrl_reg[31:1];
  assign start       = ctrl_reg[0] & ~start_ff_q;
  assign cfg_bad     = (vec_len == 32'd0) || (vec_len > 32'(MAX_LEN)) ||
                       (vec_a_addr[1:0] != 2'b00) || (vec_b_addr[1:0] != 2'b00) ||
                       (out_addr[1:0] != 2'b00);
  assign idx_nxt     = idx_q + IDX_W'(1);

  // Low ACC_W bits of the sign-extended product equal the signed product.
  always_comb begin
    a_ext = {{(ACC_W-DATA_W){a_q[DATA_W-1]}}, a_q};
    b_ext = {{(ACC_W-DATA_W){b_q[DATA_W-1]}}, b_q};
    prod  = a_ext * b_ext;
    sum   = acc_q + prod;
`ifdef ACC_SAT_EN
    if (!acc_q[ACC_W-1] && !prod[ACC_W-1] && sum[ACC_W-1]) begin
      mac_val = {1'b0, {(ACC_W-1){1'b1}}};
    end else if (acc_q[ACC_W-1] && prod[ACC_W-1] && !sum[ACC_W-1]) begin
      mac_val = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      mac_val = sum;
    end
`else
    mac_val = sum;
`endif
  end

  always_comb begin
    state_d      = state_q;
    busy_pulse_d = 1'b0;
    a_ptr_d      = a_ptr_q;
    b_ptr_d      = b_ptr_q;
    out_d        = out_q;
    len_d        = len_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    result_d     = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            state_d = S_ERR;
          end else begin
            state_d      = S_RD_A;
            busy_pulse_d = 1'b1;
            a_ptr_d      = vec_a_addr;
            b_ptr_d      = vec_b_addr;
            out_d        = out_addr;
            len_d        = vec_len[IDX_W-1:0];
            idx_d        = '0;
            acc_d        = '0;
          end
        end
      end
      S_RD_A:  if (mem.mem_req_ready) state_d = S_WAIT_A;
      S_WAIT_A: begin
        if (mem.mem_rsp_valid) begin
          if (mem.mem_rsp_err) begin
            state_d = S_ERR;
          end else begin
            a_d     = mem.mem_rsp_data;
            state_d = S_RD_B;
          end
        end
      end
      S_RD_B:  if (mem.mem_req_ready) state_d = S_WAIT_B;
      S_WAIT_B: begin
        if (mem.mem_rsp_valid) begin
          if (mem.mem_rsp_err) begin
            state_d = S_ERR;
          end else begin
            b_d     = mem.mem_rsp_data;
            state_d = S_MAC;
          end
        end
      end
      S_MAC: begin
        acc_d   = mac_val;
        idx_d   = idx_nxt;
        a_ptr_d = a_ptr_q + 32'd4;
        b_ptr_d = b_ptr_q + 32'd4;
        state_d = (idx_nxt == len_q) ? S_WR_LO : S_RD_A;
      end
      S_WR_LO: if (mem.mem_req_ready) state_d = S_WAIT_WL;
      S_WAIT_WL: begin
        if (mem.mem_rsp_valid) state_d = mem.mem_rsp_err ? S_ERR : S_WR_HI;
      end
      S_WR_HI: if (mem.mem_req_ready) state_d = S_WAIT_WH;
      S_WAIT_WH: begin
        if (mem.mem_rsp_valid) state_d = mem.mem_rsp_err ? S_ERR : S_DONE;
      end
      S_DONE: begin
        result_d = acc_q;
        state_d  = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      start_ff_q   <= 1'b0;
      busy_pulse_q <= 1'b0;
      a_ptr_q      <= '0;
      b_ptr_q      <= '0;
      out_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      start_ff_q   <= ctrl_reg[0];
      busy_pulse_q <= busy_pulse_d;
      a_ptr_q      <= a_ptr_d;
      b_ptr_q      <= b_ptr_d;
      out_q        <= out_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      result_q     <= result_d;
    end
  end

  // Request fields depend only on state and latched registers, so they hold while ready is low.
  always_comb begin
    mem.mem_req_valid = 1'b0;
    mem.mem_req_we    = 1'b0;
    mem.mem_req_addr  = '0;
    mem.mem_req_wdata = '0;
    case (state_q)
      S_RD_A: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = a_ptr_q;
      end
      S_RD_B: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = b_ptr_q;
      end
      S_WR_LO: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_we    = 1'b1;
        mem.mem_req_addr  = out_q;
        mem.mem_req_wdata = acc_q[DATA_W-1:0];
      end
      S_WR_HI: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_we    = 1'b1;
        mem.mem_req_addr  = out_q + 32'd4;
        mem.mem_req_wdata = acc_q[ACC_W-1:DATA_W];
      end
      default: begin
        mem.mem_req_valid = 1'b0;
      end
    endcase
  end

  assign set_busy  = busy_pulse_q;
  assign set_done  = (state_q == S_DONE);
  assign set_error = (state_q == S_ERR);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// tb/tb_dot_product_ctrl.sv - scoreboard bench for dot_product_ctrl with a memory responder and arithmetic reference model
module tb_dot_product_ctrl;

  localparam int MAX_LEN = 1024;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] ctrl_reg, vec_a_addr, vec_b_addr, vec_len, out_addr;
  logic        set_busy, set_done, set_error, busy;
  logic [63:0] result;

  dot_product_ctrl_if mem_if ();

  dot_product_ctrl dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .ctrl_reg   (ctrl_reg),
    .vec_a_addr (vec_a_addr),
    .vec_b_addr (vec_b_addr),
    .vec_len    (vec_len),
    .out_addr   (out_addr),
    .mem        (mem_if),
    .set_busy   (set_busy),
    .set_done   (set_done),
    .set_error  (set_error),
    .busy       (busy),
    .result     (result)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic               is_err;
    logic signed [31:0] cyc;
    logic [63:0]        res;
  } end_t;

  req_t        exp_req[$];
  end_t        exp_end[$];
  int          exp_busy[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] va[$];
  logic [31:0] vb[$];
  logic [63:0] last_result = 64'd0;

  int checks = 0;
  int errors = 0;

  int          bp_cycles = 0;
  int          err_idx   = -1;
  int          hs_cnt    = 0;
  int          wait_cnt  = 0;
  bit          rsp_pend  = 1'b0;
  logic [31:0] pend_data;
  bit          pend_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Memory responder: optional backpressure, response one cycle after each handshake.
  initial begin
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_data  = '0;
    mem_if.mem_rsp_err   = 1'b0;
    forever begin
      @(negedge ACLK);
      mem_if.mem_rsp_valid = 1'b0;
      mem_if.mem_rsp_err   = 1'b0;
      mem_if.mem_rsp_data  = '0;
      if (ARESET) begin
        mem_if.mem_req_ready = 1'b0;
        rsp_pend = 1'b0;
        wait_cnt = 0;
      end else begin
        if (rsp_pend) begin
          mem_if.mem_rsp_valid = 1'b1;
          mem_if.mem_rsp_data  = pend_data;
          mem_if.mem_rsp_err   = pend_err;
          rsp_pend = 1'b0;
        end
        if (mem_if.mem_req_valid) begin
          if (wait_cnt >= bp_cycles) begin
            mem_if.mem_req_ready = 1'b1;
            wait_cnt = 0;
            if (mem_if.mem_req_we) begin
              mem_model[mem_if.mem_req_addr] = mem_if.mem_req_wdata;
              pend_data = '0;
            end else begin
              pend_data = mem_model.exists(mem_if.mem_req_addr) ? mem_model[mem_if.mem_req_addr] : 32'hDEAD_BEEF;
            end
            pend_err = (hs_cnt == err_idx);
            hs_cnt++;
            rsp_pend = 1'b1;
          end else begin
            mem_if.mem_req_ready = 1'b0;
            wait_cnt++;
          end
        end else begin
          mem_if.mem_req_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake or a status pulse.
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  bit          cap_seen = 1'b0;
  int          cap_wait = 0;
  bit          res_pend = 1'b0;
  logic [63:0] res_exp;
  req_t        got_req;
  end_t        got_end;
  int          got_busy;

  initial begin
    forever begin
      @(negedge ACLK);
      #2;
      if (ARESET) begin
        cap_seen = 1'b0;
        res_pend = 1'b0;
      end else begin
        if (res_pend) begin
          check("result", result, res_exp);
          res_pend = 1'b0;
        end
        if (set_busy) begin
          if (exp_busy.size() == 0) begin
            fail_evt("unexpected_set_busy");
          end else begin
            got_busy = exp_busy.pop_front();
            check("set_busy_cycle", 64'(cyc), 64'(got_busy));
          end
        end
        if (set_done || set_error) begin
          check("pulse_exclusive", 64'(int'(set_busy) + int'(set_done) + int'(set_error)), 64'd1);
          if (exp_end.size() == 0) begin
            fail_evt("unexpected_end_pulse");
          end else begin
            got_end = exp_end.pop_front();
            check("end_is_error", 64'(set_error), 64'(got_end.is_err));
            if (got_end.cyc >= 0) check("end_cycle", 64'(cyc), 64'(got_end.cyc));
            res_exp  = got_end.res;
            res_pend = 1'b1;
          end
        end
        if (mem_if.mem_req_valid) begin
          if (!cap_seen) begin
            cap_addr  = mem_if.mem_req_addr;
            cap_we    = mem_if.mem_req_we;
            cap_wdata = mem_if.mem_req_wdata;
            cap_seen  = 1'b1;
            cap_wait  = 0;
          end
          if (mem_if.mem_req_ready) begin
            if (cap_wait > 0) begin
              check("req_stable_addr", 64'(mem_if.mem_req_addr), 64'(cap_addr));
              check("req_stable_we_wdata", {31'd0, mem_if.mem_req_we, mem_if.mem_req_wdata}, {31'd0, cap_we, cap_wdata});
            end
            if (exp_req.size() == 0) begin
              fail_evt("unexpected_mem_req");
            end else begin
              got_req = exp_req.pop_front();
              check("req_addr", 64'(mem_if.mem_req_addr), 64'(got_req.addr));
              check("req_we_wdata", {31'd0, mem_if.mem_req_we, mem_if.mem_req_wdata}, {31'd0, got_req.we, got_req.wdata});
            end
            cap_seen = 1'b0;
          end else begin
            cap_wait++;
          end
        end
      end
    end
  end

  // Reference: sum of signed 32x32 products, wrapping or clamped after each step.
  function automatic logic [63:0] model(input int len);
`ifdef ACC_SAT_EN
    logic signed [65:0] s;
    logic signed [65:0] smax;
    logic signed [65:0] smin;
    smax = 66'sh7FFF_FFFF_FFFF_FFFF;
    smin = -66'sh8000_0000_0000_0000;
    s = '0;
    for (int i = 0; i < len; i++) begin
      s = s + (longint'($signed(va[i])) * longint'($signed(vb[i])));
      if (s > smax) s = smax;
      if (s < smin) s = smin;
    end
    return s[63:0];
`else
    longint s;
    s = 0;
    for (int i = 0; i < len; i++) s += longint'($signed(va[i])) * longint'($signed(vb[i]));
    return s;
`endif
  endfunction

  task automatic run(input logic [31:0] aa, input logic [31:0] ba, input logic [31:0] oa,
                     input int len, input int bp, input int eidx);
    int          c, k, budget, t;
    bit          bad, aborted;
    logic [63:0] er;
    req_t        r;
    end_t        e;
    bad = (len == 0) || (len > MAX_LEN) || (aa[1:0] != 2'b00) || (ba[1:0] != 2'b00) || (oa[1:0] != 2'b00);
    @(negedge ACLK);
    vec_a_addr = aa;
    vec_b_addr = ba;
    out_addr   = oa;
    vec_len    = 32'(len);
    bp_cycles  = bp;
    err_idx    = eidx;
    hs_cnt     = 0;
    for (int i = 0; i < len && i < va.size(); i++) begin
      mem_model[aa + 32'(4 * i)] = va[i];
      mem_model[ba + 32'(4 * i)] = vb[i];
    end
    c = cyc;
    if (bad) begin
      e.is_err = 1'b1;
      e.cyc    = c + 1;
      e.res    = last_result;
      exp_end.push_back(e);
    end else begin
      exp_busy.push_back(c + 1);
      k = 0;
      aborted = 1'b0;
      for (int i = 0; i < len && !aborted; i++) begin
        r.addr = aa + 32'(4 * i); r.we = 1'b0; r.wdata = '0;
        exp_req.push_back(r);
        aborted = (k == eidx); k++;
        if (!aborted) begin
          r.addr = ba + 32'(4 * i);
          exp_req.push_back(r);
          aborted = (k == eidx); k++;
        end
      end
      if (aborted) begin
        e.is_err = 1'b1; e.cyc = -1; e.res = last_result;
      end else begin
        er = model(len);
        r.addr = oa; r.we = 1'b1; r.wdata = er[31:0];
        exp_req.push_back(r);
        r.addr = oa + 32'd4; r.wdata = er[63:32];
        exp_req.push_back(r);
        e.is_err = 1'b0;
        e.cyc    = (bp == 0) ? c + 5 * len + 5 : -1;
        e.res    = er;
        last_result = er;
      end
      exp_end.push_back(e);
    end
    ctrl_reg = ($urandom() & 32'hFFFF_FFFE) | 32'h1;
    budget = (5 * len + 20) * (bp + 2) + 20;
    t = 0;
    while ((exp_end.size() != 0 || exp_req.size() != 0 || exp_busy.size() != 0 || res_pend) && t < budget) begin
      @(negedge ACLK);
      #3;
      // A second rising start edge mid-run must be ignored.
      if (!bad && t == 2) ctrl_reg = 32'h0;
      if (!bad && t == 3) ctrl_reg = 32'h1;
      t++;
    end
    if (t >= budget) begin
      fail_evt("run_timeout");
      exp_end.delete(); exp_req.delete(); exp_busy.delete();
      res_pend = 1'b0;
    end
    ctrl_reg = 32'h0;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic reset_abort();
    int   c;
    req_t r;
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    @(negedge ACLK);
    vec_a_addr = 32'h1000; vec_b_addr = 32'h2000; out_addr = 32'h3000; vec_len = 32'd4;
    bp_cycles = 0; err_idx = -1; hs_cnt = 0;
    c = cyc;
    exp_busy.push_back(c + 1);
    r.addr = 32'h1000; r.we = 1'b0; r.wdata = '0;
    exp_req.push_back(r);
    ctrl_reg = 32'h1;
    @(negedge ACLK);
    @(negedge ACLK);
    #1 ARESET = 1'b1;
    #1;
    check("abort_req_valid", 64'(mem_if.mem_req_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_pulses", {61'd0, set_busy, set_done, set_error}, 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_seen_accept_and_read", 64'(exp_busy.size() + exp_req.size()), 64'd0);
    ctrl_reg = 32'h0;
    exp_end.delete(); exp_req.delete(); exp_busy.delete();
    last_result = 64'd0;
    repeat (2) @(negedge ACLK);
    #1 ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctrl_reg = 32'h0; vec_a_addr = '0; vec_b_addr = '0; vec_len = '0; out_addr = '0;
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    #1;
    check("reset_req_valid", 64'(mem_if.mem_req_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_pulses", {61'd0, set_busy, set_done, set_error}, 64'd0);
    check("reset_result", result, 64'd0);

    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    run(32'h1000, 32'h2000, 32'h3000, 4, 0, -1);
    check("basic_result", result, 64'd70);
    check("basic_word_lo", 64'(mem_model[32'h3000]), 64'h46);
    check("basic_word_hi", 64'(mem_model[32'h3004]), 64'h0);

    va = '{32'hFFFF_FFFD};
    vb = '{32'd7};
    run(32'h1100, 32'h2100, 32'h3100, 1, 0, -1);
    check("signed_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    check("signed_word_lo", 64'(mem_model[32'h3100]), 64'hFFFF_FFEB);
    check("signed_word_hi", 64'(mem_model[32'h3104]), 64'hFFFF_FFFF);

    va = '{32'd1, 32'd2};
    vb = '{32'd3, 32'd4};
    run(32'h1000, 32'h2000, 32'h3000, 0, 0, -1);
    run(32'h1002, 32'h2000, 32'h3000, 2, 0, -1);
    run(32'h1000, 32'h2001, 32'h3000, 2, 0, -1);
    run(32'h1000, 32'h2000, 32'h3003, 2, 0, -1);
    run(32'h1000, 32'h2000, 32'h3000, MAX_LEN + 1, 0, -1);
    check("illegal_result_held", result, 64'hFFFF_FFFF_FFFF_FFEB);

    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    run(32'h1200, 32'h2200, 32'h3200, 4, 3, -1);
    check("backpressure_result", result, 64'd70);

    mem_model[32'h3300] = 32'h5A5A_5A5A;
    run(32'h1300, 32'h2300, 32'h3300, 4, 0, 3);
    check("rsp_err_result_held", result, 64'd70);
    check("rsp_err_no_write", 64'(mem_model[32'h3300]), 64'h5A5A_5A5A);

    reset_abort();
    run(32'h1000, 32'h2000, 32'h3000, 4, 0, -1);
    check("after_reset_result", result, 64'd70);

    va = '{32'h8000_0000, 32'h8000_0000};
    vb = '{32'h8000_0000, 32'h8000_0000};
    run(32'h1400, 32'h2400, 32'h3400, 2, 0, -1);
`ifdef ACC_SAT_EN
    check("overflow_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    check("overflow_result", result, 64'h8000_0000_0000_0000);
`endif

    va.delete(); vb.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      va.push_back($urandom());
      vb.push_back($urandom());
    end
    run(32'h4_0000, 32'h5_0000, 32'h6_0000, MAX_LEN, 0, -1);

    for (int n = 0; n < 6; n++) begin
      int len;
      len = $urandom_range(1, 8);
      va.delete(); vb.delete();
      for (int i = 0; i < len; i++) begin
        va.push_back($urandom());
        vb.push_back($urandom());
      end
      run(32'h7_0000 + 32'(n * 64), 32'h8_0000 + 32'(n * 64), 32'h9_0000 + 32'(n * 8),
          len, $urandom_range(0, 2), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_ctrl.md
Name: dot_product_ctrl

Overview:
Sequencer for the dot-product accelerator, placed between the AXI-lite register block and the shared memory port. Starts on a rising edge of control bit REG0[0], then reads A[i] and B[i] from memory over a single-outstanding request/response port. It multiply-accumulates the pairs and writes the 64-bit result to the output address as two 32-bit words. It reports progress to the status register through one-cycle set_busy, set_done and set_error pulses.

Parameters:
DATA_W, 32, element and memory data width (signed two's complement)
ACC_W, 64, accumulator width; fixed at 2*DATA_W
MAX_LEN, 1024, largest legal vector length

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous, active-high reset
ctrl_reg  in  32  REG0 value; bit0 = start
vec_a_addr  in  32  REG1, byte base address of A
vec_b_addr  in  32  REG2, byte base address of B
vec_len  in  32  REG3, element count
out_addr  in  32  REG4, byte address of result
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = write, 0 = read
mem_req_addr  out  32  byte address
mem_req_wdata  out  32  write data
mem_rsp_valid  in  1  read data or write acknowledge valid
mem_rsp_data  in  32  read data
mem_rsp_err  in  1  response error, qualified by mem_rsp_valid
set_busy  out  1  one-cycle pulse on accepted start
set_done  out  1  one-cycle pulse on completion
set_error  out  1  one-cycle pulse on failure
busy  out  1  high in any state except IDLE
result  out  64  last accumulator value, held until the next start

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, start edge register 0, accumulator, index and result 0. Reset asserted at any time aborts immediately: mem_req_valid drops asynchronously and no pulse is emitted.
- Start: start_ff <= ctrl_reg[0] every cycle. A start is start = ctrl_reg[0] & ~start_ff. It is accepted only in IDLE; starts seen in other states are ignored.
- Config check on an accepted start:
  - Error if vec_len == 0, vec_len > MAX_LEN, or any of the three addresses has [1:0] != 0.
  - On error: go to ERR. set_error pulses the next cycle. No memory request is issued.
  - Otherwise: set_busy pulses, addresses and length are latched, acc = 0, idx = 0, and the FSM goes to RD_A.
- States: IDLE, RD_A, WAIT_A, RD_B, WAIT_B, MAC, WR_LO, WAIT_WL, WR_HI, WAIT_WH, DONE, ERR.
- RD_A / RD_B / WR_LO / WR_HI:
  - mem_req_valid = 1 with addr, we and wdata stable until mem_req_ready.
  - On handshake, go to the matching WAIT state.
  - Request data: RD_A reads a_ptr, RD_B reads b_ptr, WR_LO writes acc[31:0] to out_addr, WR_HI writes acc[63:32] to out_addr+4.
- WAIT states:
  - mem_rsp_valid is legal no earlier than the cycle after the handshake; mem_rsp_valid in any non-WAIT state is ignored.
  - On mem_rsp_valid & mem_rsp_err: go to ERR; no further requests.
  - Otherwise WAIT_A captures a, WAIT_B captures b, WAIT_WL goes to WR_HI, WAIT_WH goes to DONE.
- MAC:
  - acc <= acc + signed(a)*signed(b), wrapping modulo 2^64.
  - idx++, a_ptr += 4, b_ptr += 4 (32-bit wrap).
  - If idx+1 == len go to WR_LO, else RD_A.
- DONE: set_done = 1 for one cycle, result <= acc, then IDLE.
- ERR: set_error = 1 for one cycle, then IDLE; result is unchanged.
- Latency with ready always high and response one cycle after handshake: 5 cycles per element. Start-to-set_done = 5*len + 5 cycles after the start-accept cycle.
- set_busy, set_done and set_error are never high in the same cycle.

Optional Feature:
Macro ACC_SAT_EN.
- Defined: each MAC saturates signed to 0x7FFF_FFFF_FFFF_FFFF or 0x8000_0000_0000_0000 on overflow.
- Undefined: accumulation wraps modulo 2^64.

Test Plan:
- Basic dot product:
  - Stimulus: len=4, A=[1,2,3,4], B=[5,6,7,8], zero-wait memory.
  - Response: writes 0x46 to out_addr and 0x0 to out_addr+4; set_done 25 cycles after accept; result = 70.
- Signed product:
  - Stimulus: len=1, A=[-3], B=[7].
  - Response: writes 0xFFFFFFEB then 0xFFFFFFFF; result = -21.
- Illegal config:
  - Stimulus: len=0; then vec_a_addr=0x1002 with len=2.
  - Response: set_error one cycle after accept each time; mem_req_valid never asserted; set_busy never asserted.
- Backpressure:
  - Stimulus: mem_req_ready low for 3 cycles on every request.
  - Response: addr, we and wdata stable throughout; result still 70 for the basic vectors.
- Error and reset aborts:
  - Stimulus: mem_rsp_err on the second B read.
  - Response: set_error pulse, no writes, result unchanged.
  - Stimulus: ARESET asserted in WAIT_A.
  - Response: IDLE, all outputs 0; a fresh start afterwards completes normally.
- Overflow:
  - Stimulus: len=2, A=B=[0x80000000,0x80000000].
  - Response: result 0x8000_0000_0000_0000 without ACC_SAT_EN; 0x7FFF_FFFF_FFFF_FFFF with ACC_SAT_EN.
